// File: rtl/config_shift_receiver_if.sv
// Three-wire configuration link (enable, sclk, data).
// The transmitter drives all three wires (master); the chip-side receiver
// only observes them (slave).
//   cfg_enable_i : frame enable, high for the whole frame
//   cfg_sclk_i   : shift clock, data sampled on its rising edge
//   cfg_data_i   : serial data, LSB first
interface config_shift_receiver_if;
    logic cfg_enable_i;
    logic cfg_sclk_i;
    logic cfg_data_i;

    modport master (
        output cfg_enable_i,
        output cfg_sclk_i,
        output cfg_data_i
    );

    modport slave (
        input cfg_enable_i,
        input cfg_sclk_i,
        input cfg_data_i
    );
endinterface

// File: rtl/config_shift_receiver.sv
// Chip-side receiver for the 3-wire configuration link.
// Deserialises one 52-bit frame sent LSB first. Frames with exactly 52 bits
// are committed to the live mandelbrot configuration registers. Frames of
// any other length are discarded and flagged.
// Ports:
//   clk, rst_n    : system clock, asynchronous active-low reset
//   link (slave)  : enable / sclk / data wires, asynchronous to clk
//   cfg_x_o       : frame bits [15:0],  x start
//   cfg_y_o       : frame bits [31:16], y start
//   cfg_scale_o   : frame bits [38:32], step/scale
//   cfg_shift_o   : frame bits [41:39], colour shift
//   cfg_iter_o    : frame bits [51:42], max iteration mask
//   cfg_valid_o   : one-cycle pulse, new configuration committed
//   cfg_error_o   : one-cycle pulse, frame discarded (bit count != 52)
//   cfg_busy_o    : synchronised enable, a frame is in progress
module config_shift_receiver #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [51:0] RESET_CFG   = 52'h03C7F_B500_6080
) (
    input  logic                          clk,
    input  logic                          rst_n,
    config_shift_receiver_if.slave        link,
    output logic [15:0]                   cfg_x_o,
    output logic [15:0]                   cfg_y_o,
    output logic [6:0]                    cfg_scale_o,
    output logic [2:0]                    cfg_shift_o,
    output logic [9:0]                    cfg_iter_o,
    output logic                          cfg_valid_o,
    output logic                          cfg_error_o,
    output logic                          cfg_busy_o
);

    localparam logic [5:0] FRAME_BITS = 6'd52;
    localparam logic [5:0] CNT_MAX    = 6'd63;

    // Synchroniser chains; all three share one depth so data stays aligned
    // with the sclk edge that samples it.
    logic [SYNC_STAGES-1:0] en_sync_r;
    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] dat_sync_r;
    // One extra flop on enable and sclk for edge detection.
    logic                   en_prev_r;
    logic                   sck_prev_r;

    logic        en_s;
    logic        sck_s;
    logic        dat_s;
    logic        en_rise_s;
    logic        en_fall_s;
    logic        sck_rise_s;

    logic [51:0] shadow_r;
    logic [51:0] shadow_nxt_s;
    logic [5:0]  bit_cnt_r;
    logic [5:0]  bit_cnt_nxt_s;

    logic [51:0] cfg_r;
    logic [51:0] cfg_nxt_s;
    logic        valid_r;
    logic        valid_nxt_s;
    logic        error_r;
    logic        error_nxt_s;

    assign en_s       = en_sync_r[SYNC_STAGES-1];
    assign sck_s      = sck_sync_r[SYNC_STAGES-1];
    assign dat_s      = dat_sync_r[SYNC_STAGES-1];
    assign en_rise_s  = en_s & ~en_prev_r;
    assign en_fall_s  = ~en_s & en_prev_r;
    assign sck_rise_s = sck_s & ~sck_prev_r;

    // Input synchronisers plus edge-detect history flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_sync_r  <= '0;
            sck_sync_r <= '0;
            dat_sync_r <= '0;
            en_prev_r  <= 1'b0;
            sck_prev_r <= 1'b0;
        end else begin
            en_sync_r  <= {en_sync_r[SYNC_STAGES-2:0],  link.cfg_enable_i};
            sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], link.cfg_sclk_i};
            dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], link.cfg_data_i};
            en_prev_r  <= en_s;
            sck_prev_r <= sck_s;
        end
    end

    // Shadow shift and bit counting. en_rise implies en_s, so a bit arriving
    // in the same cycle as the frame start is still captured and counted as 1.
    always_comb begin
        shadow_nxt_s  = shadow_r;
        bit_cnt_nxt_s = bit_cnt_r;
        if (sck_rise_s && en_s) begin
            shadow_nxt_s = {dat_s, shadow_r[51:1]};
        end else begin
            shadow_nxt_s = shadow_r;
        end
        if (en_rise_s) begin
            bit_cnt_nxt_s = sck_rise_s ? 6'd1 : 6'd0;
        end else if (sck_rise_s && en_s && (bit_cnt_r != CNT_MAX)) begin
            bit_cnt_nxt_s = bit_cnt_r + 6'd1;
        end else begin
            bit_cnt_nxt_s = bit_cnt_r;
        end
    end

    // Frame end: commit the whole shadow at once, or flag a bad length.
    always_comb begin
        cfg_nxt_s   = cfg_r;
        valid_nxt_s = 1'b0;
        error_nxt_s = 1'b0;
        if (en_fall_s) begin
            if (bit_cnt_r == FRAME_BITS) begin
                cfg_nxt_s   = shadow_r;
                valid_nxt_s = 1'b1;
            end else begin
                error_nxt_s = 1'b1;
            end
        end else begin
            cfg_nxt_s = cfg_r;
        end
    end

    // Shadow, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r  <= 52'd0;
            bit_cnt_r <= 6'd0;
            cfg_r     <= RESET_CFG;
            valid_r   <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            shadow_r  <= shadow_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            cfg_r     <= cfg_nxt_s;
            valid_r   <= valid_nxt_s;
            error_r   <= error_nxt_s;
        end
    end

    assign cfg_x_o     = cfg_r[15:0];
    assign cfg_y_o     = cfg_r[31:16];
    assign cfg_scale_o = cfg_r[38:32];
    assign cfg_shift_o = cfg_r[41:39];
    assign cfg_iter_o  = cfg_r[51:42];
    assign cfg_valid_o = valid_r;
    assign cfg_error_o = error_r;
    // en_prev_r is the registered synchronised enable.
    assign cfg_busy_o  = en_prev_r;

endmodule

// File: tb/tb_config_shift_receiver.sv
module tb_config_shift_receiver;

    localparam logic [51:0] RESET_CFG = 52'h03C7F_B500_6080;

    logic        clk;
    logic        rst_n;
    logic [15:0] cfg_x;
    logic [15:0] cfg_y;
    logic [6:0]  cfg_scale;
    logic [2:0]  cfg_shift;
    logic [9:0]  cfg_iter;
    logic        cfg_valid;
    logic        cfg_error;
    logic        cfg_busy;
    logic [51:0] obs;

    int passed = 0;
    int total  = 0;

    // Reference model: the configuration that should currently be live.
    logic [51:0] model_cfg;

    config_shift_receiver_if link();

    config_shift_receiver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .link        (link),
        .cfg_x_o     (cfg_x),
        .cfg_y_o     (cfg_y),
        .cfg_scale_o (cfg_scale),
        .cfg_shift_o (cfg_shift),
        .cfg_iter_o  (cfg_iter),
        .cfg_valid_o (cfg_valid),
        .cfg_error_o (cfg_error),
        .cfg_busy_o  (cfg_busy)
    );

    assign obs = {cfg_iter, cfg_shift, cfg_scale, cfg_y, cfg_x};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send n bits, first bit = bits[0]; sclk 1 clk low (data set) / 1 clk high.
    task automatic tx_bits(input logic [69:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            link.cfg_data_i = bits[i];
            link.cfg_sclk_i = 1'b0;
            tick();
            link.cfg_sclk_i = 1'b1;
            tick();
        end
        link.cfg_sclk_i = 1'b0;
        tick();
    endtask

    task automatic start_frame();
        link.cfg_enable_i = 1'b1;
        repeat (3) tick();
    endtask

    // Drop enable and watch for pulses over a bounded number of cycles.
    task automatic end_frame(input int cycles, output int vc, output int ec, output int vcyc);
        link.cfg_enable_i = 1'b0;
        vc = 0; ec = 0; vcyc = -1;
        for (int c = 1; c <= cycles; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (cfg_valid === 1'b1) begin
                vc++;
                if (vcyc < 0) vcyc = c;
            end
            if (cfg_error === 1'b1) ec++;
        end
    endtask

    task automatic do_frame(input logic [69:0] bits, input int n, input int cycles,
                            output int vc, output int ec, output int vcyc, output logic busy_mid);
        start_frame();
        tx_bits(bits, n);
        busy_mid = cfg_busy;
        end_frame(cycles, vc, ec, vcyc);
        if (n == 52) model_cfg = bits[51:0];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        link.cfg_enable_i = 1'b0;
        link.cfg_sclk_i   = 1'b0;
        link.cfg_data_i   = 1'b0;
        model_cfg = RESET_CFG;
        repeat (3) @(negedge clk);
        total++;
        if (obs !== RESET_CFG) $display("FAIL reset_cfg got %h want %h", obs, RESET_CFG);
        else passed++;
        total++;
        if ({cfg_x, cfg_y, cfg_scale, cfg_shift, cfg_iter} !== {16'h6080, 16'hB500, 7'h7F, 3'b000, 10'h00F})
            $display("FAIL reset_fields got %h %h %h %h %h", cfg_x, cfg_y, cfg_scale, cfg_shift, cfg_iter);
        else passed++;
        total++;
        if ({cfg_valid, cfg_error, cfg_busy} !== 3'b000)
            $display("FAIL reset_flags got %b want 000", {cfg_valid, cfg_error, cfg_busy});
        else passed++;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_spec_frame();
        int vc, ec, vcyc;
        logic busy_mid;
        logic [69:0] bits;
        bits = {18'd0, 10'h01F, 3'b001, 7'h7F, 16'hB500, 16'h6080};
        do_frame(bits, 52, 8, vc, ec, vcyc, busy_mid);
        total++;
        if (obs !== model_cfg) $display("FAIL spec_cfg got %h want %h", obs, model_cfg);
        else passed++;
        total++;
        if (cfg_iter !== 10'h01F || cfg_shift !== 3'b001)
            $display("FAIL spec_fields got iter %h shift %b want 01f 001", cfg_iter, cfg_shift);
        else passed++;
        total++;
        if (vc !== 1 || ec !== 0) $display("FAIL spec_pulses got valid %0d error %0d want 1 0", vc, ec);
        else passed++;
        total++;
        if (vcyc !== 3) $display("FAIL spec_latency got edge %0d want 3", vcyc);
        else passed++;
        total++;
        if (busy_mid !== 1'b1 || cfg_busy !== 1'b0)
            $display("FAIL spec_busy got mid %b after %b want 1 0", busy_mid, cfg_busy);
        else passed++;
    endtask

    task automatic test_bad_length();
        int lens[3] = '{51, 60, 70};
        int vc, ec, vcyc;
        logic busy_mid;
        logic [69:0] bits;
        foreach (lens[k]) begin
            bits = {$urandom, $urandom, $urandom};
            do_frame(bits, lens[k], 8, vc, ec, vcyc, busy_mid);
            total++;
            if (vc !== 0 || ec !== 1)
                $display("FAIL len%0d_pulses got valid %0d error %0d want 0 1", lens[k], vc, ec);
            else passed++;
            total++;
            if (obs !== model_cfg) $display("FAIL len%0d_hold got %h want %h", lens[k], obs, model_cfg);
            else passed++;
        end
    endtask

    task automatic test_ignored_sclk();
        int vc, ec, vcyc, pulses;
        logic busy_mid;
        logic [69:0] bits;
        pulses = 0;
        link.cfg_enable_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            link.cfg_data_i = 1'($urandom);
            link.cfg_sclk_i = 1'b0;
            tick();
            if (cfg_valid === 1'b1 || cfg_error === 1'b1) pulses++;
            link.cfg_sclk_i = 1'b1;
            tick();
            if (cfg_valid === 1'b1 || cfg_error === 1'b1) pulses++;
        end
        link.cfg_sclk_i = 1'b0;
        repeat (4) tick();
        total++;
        if (pulses !== 0 || obs !== model_cfg)
            $display("FAIL idle_sclk got pulses %0d cfg %h want 0 %h", pulses, obs, model_cfg);
        else passed++;
        bits = {$urandom, $urandom, $urandom};
        do_frame(bits, 52, 8, vc, ec, vcyc, busy_mid);
        total++;
        if (obs !== model_cfg || vc !== 1 || ec !== 0)
            $display("FAIL idle_then_frame got %h v%0d e%0d want %h v1 e0", obs, vc, ec, model_cfg);
        else passed++;
    endtask

    task automatic test_random();
        int vc, ec, vcyc, n;
        logic busy_mid;
        logic [69:0] bits;
        for (int r = 0; r < 8; r++) begin
            bits = {$urandom, $urandom, $urandom};
            n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(40, 63)) : 52;
            do_frame(bits, n, 8, vc, ec, vcyc, busy_mid);
            total++;
            if (obs !== model_cfg || vc !== (n == 52 ? 1 : 0) || ec !== (n == 52 ? 0 : 1))
                $display("FAIL rand%0d n=%0d got %h v%0d e%0d want %h", r, n, obs, vc, ec, model_cfg);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int vc, ec, vcyc;
        logic busy_mid;
        logic [69:0] bits;
        for (int f = 0; f < 2; f++) begin
            bits = {$urandom, $urandom, $urandom};
            do_frame(bits, 52, 3, vc, ec, vcyc, busy_mid);
            total++;
            if (obs !== model_cfg || vc !== 1 || vcyc !== 3)
                $display("FAIL b2b%0d got %h v%0d at %0d want %h v1 at 3", f, obs, vc, vcyc, model_cfg);
            else passed++;
        end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        int vc, ec, vcyc, pulses;
        logic [69:0] bits;
        bits = {$urandom, $urandom, $urandom};
        start_frame();
        tx_bits(bits, 20);
        rst_n = 1'b0;
        model_cfg = RESET_CFG;
        @(negedge clk);
        total++;
        if (obs !== RESET_CFG || {cfg_valid, cfg_error, cfg_busy} !== 3'b000)
            $display("FAIL midrst_state got %h %b want %h 000", obs, {cfg_valid, cfg_error, cfg_busy}, RESET_CFG);
        else passed++;
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (cfg_valid === 1'b1 || cfg_error === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 0 || cfg_busy !== 1'b1 || obs !== RESET_CFG)
            $display("FAIL midrst_wait got pulses %0d busy %b cfg %h want 0 1 %h", pulses, cfg_busy, obs, RESET_CFG);
        else passed++;
        // Enable stayed high: a fresh en_rise was seen, so 52 more bits form a frame.
        bits = {$urandom, $urandom, $urandom};
        tx_bits(bits, 52);
        end_frame(8, vc, ec, vcyc);
        model_cfg = bits[51:0];
        total++;
        if (obs !== model_cfg || vc !== 1 || ec !== 0)
            $display("FAIL midrst_next got %h v%0d e%0d want %h v1 e0", obs, vc, ec, model_cfg);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_spec_frame();
        test_bad_length();
        test_ignored_sclk();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
